// File: rtl/midi_msg_parser.sv
// MIDI channel-voice message parser with running status; emits one registered event per message.
// Optional channel filter enabled by defining MIDI_CHAN_FILTER_EN (events only on CHANNEL).
module midi_msg_parser #(
    parameter int unsigned CHANNEL = 0
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       ev_valid,
    output logic [2:0] ev_type,
    output logic [3:0] ev_chan,
    output logic [6:0] ev_d1,
    output logic [6:0] ev_d2
);

    typedef enum logic [1:0] {StIdle, StD1, StD2, StSysex} state_e;

`ifdef MIDI_CHAN_FILTER_EN
    localparam bit FilterEn = 1'b1;
`else
    localparam bit FilterEn = 1'b0;
`endif
    localparam logic [3:0] FilterChan = 4'(CHANNEL);

    state_e     state_q, state_d;
    logic       rs_ok_q, rs_ok_d;
    logic [2:0] type_q, type_d;
    logic [3:0] chan_q, chan_d;
    logic [6:0] d1_q, d1_d;

    logic       ev_valid_q, ev_valid_d;
    logic [2:0] ev_type_q, ev_type_d;
    logic [3:0] ev_chan_q, ev_chan_d;
    logic [6:0] ev_d1_q, ev_d1_d;
    logic [6:0] ev_d2_q, ev_d2_d;

    logic       emit;
    logic [6:0] emit_d1;
    logic [6:0] emit_d2;
    logic       one_byte;
    logic       chan_ok;

    // Program change (C0) and channel aftertouch (D0) carry a single data byte.
    assign one_byte = (type_q == 3'd4) || (type_q == 3'd5);
    assign chan_ok  = !FilterEn || (chan_q == FilterChan);

    always_comb begin
        state_d    = state_q;
        rs_ok_d    = rs_ok_q;
        type_d     = type_q;
        chan_d     = chan_q;
        d1_d       = d1_q;
        ev_valid_d = 1'b0;
        ev_type_d  = ev_type_q;
        ev_chan_d  = ev_chan_q;
        ev_d1_d    = ev_d1_q;
        ev_d2_d    = ev_d2_q;
        emit       = 1'b0;
        emit_d1    = d1_q;
        emit_d2    = 7'd0;

        if (rx_valid && (rx_data < 8'hF8)) begin
            if (rx_data[7]) begin
                if (rx_data < 8'hF0) begin
                    type_d  = rx_data[6:4];
                    chan_d  = rx_data[3:0];
                    rs_ok_d = 1'b1;
                    state_d = StD1;
                end else if (rx_data == 8'hF0) begin
                    rs_ok_d = 1'b0;
                    state_d = StSysex;
                end else begin
                    rs_ok_d = 1'b0;
                    state_d = StIdle;
                end
            end else begin
                unique case (state_q)
                    StIdle, StD1: begin
                        if ((state_q == StD1) || rs_ok_q) begin
                            d1_d = rx_data[6:0];
                            if (one_byte) begin
                                emit    = 1'b1;
                                emit_d1 = rx_data[6:0];
                                state_d = StIdle;
                            end else begin
                                state_d = StD2;
                            end
                        end
                    end
                    StD2: begin
                        emit    = 1'b1;
                        emit_d2 = rx_data[6:0];
                        state_d = StIdle;
                    end
                    StSysex: ;
                    default: state_d = StIdle;
                endcase
            end
        end

        if (emit && chan_ok) begin
            ev_valid_d = 1'b1;
            // Note-on with zero velocity is reported as note-off.
            ev_type_d  = ((type_q == 3'd1) && (emit_d2 == 7'd0)) ? 3'd0 : type_q;
            ev_chan_d  = chan_q;
            ev_d1_d    = emit_d1;
            ev_d2_d    = emit_d2;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rs_ok_q    <= 1'b0;
            type_q     <= 3'd0;
            chan_q     <= 4'd0;
            d1_q       <= 7'd0;
            ev_valid_q <= 1'b0;
            ev_type_q  <= 3'd0;
            ev_chan_q  <= 4'd0;
            ev_d1_q    <= 7'd0;
            ev_d2_q    <= 7'd0;
        end else begin
            state_q    <= state_d;
            rs_ok_q    <= rs_ok_d;
            type_q     <= type_d;
            chan_q     <= chan_d;
            d1_q       <= d1_d;
            ev_valid_q <= ev_valid_d;
            ev_type_q  <= ev_type_d;
            ev_chan_q  <= ev_chan_d;
            ev_d1_q    <= ev_d1_d;
            ev_d2_q    <= ev_d2_d;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_type  = ev_type_q;
    assign ev_chan  = ev_chan_q;
    assign ev_d1    = ev_d1_q;
    assign ev_d2    = ev_d2_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Table-driven bench for midi_msg_parser: byte vectors with expected events fed to a scoreboard.
module tb_midi_msg_parser;

`ifdef MIDI_CHAN_FILTER_EN
    localparam bit FilterEn = 1'b1;
`else
    localparam bit FilterEn = 1'b0;
`endif
    localparam logic [3:0] TbChan = 4'd1;

    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       ev_valid;
    logic [2:0] ev_type;
    logic [3:0] ev_chan;
    logic [6:0] ev_d1;
    logic [6:0] ev_d2;

    midi_msg_parser #(.CHANNEL(1)) dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .ev_valid(ev_valid),
        .ev_type (ev_type),
        .ev_chan (ev_chan),
        .ev_d1   (ev_d1),
        .ev_d2   (ev_d2)
    );

    always #10 clk_50m = ~clk_50m;

    typedef struct {
        logic [7:0] b;
        bit         rst;
        bit         exp;
        logic [2:0] t;
        logic [3:0] c;
        logic [6:0] d1;
        logic [6:0] d2;
    } vec_t;

    typedef struct {
        logic [2:0] t;
        logic [3:0] c;
        logic [6:0] d1;
        logic [6:0] d2;
        int         due;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   cycle = 0;
    int   tests = 0;
    int   fails = 0;
    bit   monitor_on = 1'b0;

    always @(posedge clk_50m) cycle <= cycle + 1;

    task automatic nb(input logic [7:0] b);
        vecs.push_back('{b: b, rst: 1'b0, exp: 1'b0, t: 3'd0, c: 4'd0, d1: 7'd0, d2: 7'd0});
    endtask

    task automatic eb(input logic [7:0] b, input logic [2:0] t, input logic [3:0] c,
                      input logic [6:0] d1, input logic [6:0] d2);
        vecs.push_back('{b: b, rst: 1'b0, exp: 1'b1, t: t, c: c, d1: d1, d2: d2});
    endtask

    task automatic rb();
        vecs.push_back('{b: 8'h00, rst: 1'b1, exp: 1'b0, t: 3'd0, c: 4'd0, d1: 7'd0, d2: 7'd0});
    endtask

    task automatic check_fields(input string name, input logic [2:0] t, input logic [3:0] c,
                                input logic [6:0] d1, input logic [6:0] d2);
        tests++;
        if (ev_type !== t || ev_chan !== c || ev_d1 !== d1 || ev_d2 !== d2) begin
            fails++;
            $display("FAIL %s: got t=%0d c=%0d d1=%h d2=%h, want t=%0d c=%0d d1=%h d2=%h",
                     name, ev_type, ev_chan, ev_d1, ev_d2, t, c, d1, d2);
        end
    endtask

    // Scoreboard: every ev_valid must match the oldest expected event, on its due cycle.
    always @(negedge clk_50m) begin
        if (monitor_on && rst_n && ev_valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got t=%0d c=%0d d1=%h d2=%h at cycle %0d, want none",
                         ev_type, ev_chan, ev_d1, ev_d2, cycle);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (ev_type !== e.t || ev_chan !== e.c || ev_d1 !== e.d1 || ev_d2 !== e.d2 ||
                    cycle != e.due) begin
                    fails++;
                    $display("FAIL event: got t=%0d c=%0d d1=%h d2=%h cyc=%0d, want t=%0d c=%0d d1=%h d2=%h cyc=%0d",
                             ev_type, ev_chan, ev_d1, ev_d2, cycle, e.t, e.c, e.d1, e.d2, e.due);
                end
            end
        end
    end

    initial begin
        logic [2:0] lt;
        logic [3:0] lc;
        logic [6:0] l1;
        logic [6:0] l2;

        // 1: basic note-on
        nb(8'h90); nb(8'h3C); eb(8'h64, 3'd1, 4'd0, 7'h3C, 7'h64);
        // 2: running status, velocity 0 becomes note-off
        nb(8'h92); nb(8'h40); eb(8'h50, 3'd1, 4'd2, 7'h40, 7'h50);
        nb(8'h41); eb(8'h00, 3'd0, 4'd2, 7'h41, 7'h00);
        // 3: program change with running status
        nb(8'hC5); eb(8'h07, 3'd4, 4'd5, 7'h07, 7'h00); eb(8'h08, 3'd4, 4'd5, 7'h08, 7'h00);
        // 4: real-time byte mid-message
        nb(8'h90); nb(8'h3C); nb(8'hF8); eb(8'h64, 3'd1, 4'd0, 7'h3C, 7'h64);
        // 5: sysex, then data after F7 is discarded
        nb(8'hF0); nb(8'h7E); nb(8'h01); nb(8'hF7); nb(8'h3C); nb(8'h64);
        // 6: pitch bend, then reset mid-message
        nb(8'hE1); nb(8'h00); eb(8'h40, 3'd6, 4'd1, 7'h00, 7'h40);
        nb(8'hB3); nb(8'h07); rb(); nb(8'h7F);
        // Remaining message types and corner cases
        nb(8'h80); nb(8'h30); eb(8'h40, 3'd0, 4'd0, 7'h30, 7'h40);
        nb(8'hA4); nb(8'h3C); eb(8'h20, 3'd2, 4'd4, 7'h3C, 7'h20);
        nb(8'hD9); eb(8'h55, 3'd5, 4'd9, 7'h55, 7'h00);
        nb(8'hBF); nb(8'h07); eb(8'h64, 3'd3, 4'hF, 7'h07, 7'h64);
        nb(8'h90); nb(8'h3C); nb(8'h93); nb(8'h3C); eb(8'h40, 3'd1, 4'd3, 7'h3C, 7'h40);
        nb(8'hF0); nb(8'h01); nb(8'h02); nb(8'hB2); nb(8'h07); eb(8'h10, 3'd3, 4'd2, 7'h07, 7'h10);
        nb(8'h93); nb(8'h40); nb(8'hF2); nb(8'h10); nb(8'h20);
        nb(8'h91); nb(8'h3C); eb(8'h64, 3'd1, 4'd1, 7'h3C, 7'h64);
        nb(8'hFE); nb(8'h3D); eb(8'h65, 3'd1, 4'd1, 7'h3D, 7'h65);
        nb(8'h90); nb(8'h3C); eb(8'h64, 3'd1, 4'd0, 7'h3C, 7'h64);

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk_50m);
        #1;
        tests++;
        if (ev_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b, want 0", ev_valid);
        end
        check_fields("reset_fields", 3'd0, 4'd0, 7'd0, 7'd0);
        @(negedge clk_50m);
        rst_n      = 1'b1;
        monitor_on = 1'b1;
        lt = 3'd0; lc = 4'd0; l1 = 7'd0; l2 = 7'd0;

        foreach (vecs[i]) begin
            @(posedge clk_50m);
            #1;
            if (vecs[i].rst) begin
                rx_valid = 1'b0;
                rst_n    = 1'b0;
                #3;
                rst_n    = 1'b1;
                lt = 3'd0; lc = 4'd0; l1 = 7'd0; l2 = 7'd0;
                check_fields("midreset_fields", lt, lc, l1, l2);
            end else begin
                rx_data  = vecs[i].b;
                rx_valid = 1'b1;
                if (vecs[i].exp && (!FilterEn || vecs[i].c == TbChan)) begin
                    sb.push_back('{t: vecs[i].t, c: vecs[i].c, d1: vecs[i].d1, d2: vecs[i].d2,
                                   due: cycle + 1});
                    lt = vecs[i].t; lc = vecs[i].c; l1 = vecs[i].d1; l2 = vecs[i].d2;
                end
            end
        end
        @(posedge clk_50m);
        #1;
        rx_valid = 1'b0;
        repeat (4) @(posedge clk_50m);
        #1;

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL missing_events: got %0d outstanding, want 0", sb.size());
        end
        check_fields("hold_fields", lt, lc, l1, l2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
